// File: rtl/regfile_multiply_unit.sv
// -----------------------------------------------------------------------------
// regfile_multiply_unit
//
// Iterative shift-add multiplier placed behind the RegisterFile read ports.
// It latches a multiplicand and a multiplier and runs one add/shift step per
// clock for WIDTH clocks. It then produces a one-cycle write-back into the
// RegisterFile write port:
//   - HighHalf=0 returns the low half of the product (MUL).
//   - HighHalf=1 returns the high half of the product (UMULH, unsigned).
// X31 is the zero register, so a write-back to it is never enabled.
//
// Ports
//   Clk       in   1      clock, rising edge
//   Reset     in   1      asynchronous active-high reset
//   Start     in   1      operation request, sampled only while idle
//   BusA      in   WIDTH  multiplicand
//   BusB      in   WIDTH  multiplier
//   Rd        in   AW     destination register, latched with Start
//   HighHalf  in   1      result half select, latched with Start
//   Busy      out  1      high while running and during write-back
//   Done      out  1      one-cycle pulse during write-back
//   RW        out  AW     write-back register address
//   BusW      out  WIDTH  write-back data
//   RegWr     out  1      write enable, suppressed for X31
// -----------------------------------------------------------------------------
module regfile_multiply_unit #(
    parameter int WIDTH = 64,
    parameter int AW    = 5,
    parameter int CNTW  = 7
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [AW-1:0]    Rd,
    input  logic             HighHalf,
    output logic             Busy,
    output logic             Done,
    output logic [AW-1:0]    RW,
    output logic [WIDTH-1:0] BusW,
    output logic             RegWr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [AW-1:0]   ZERO_REG = {AW{1'b1}};
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH:0]   r_hi;      // one extra bit keeps the adder carry
    logic [WIDTH-1:0] r_lo;      // multiplier, shifted out as product low half
    logic [CNTW-1:0]  r_cnt;
    logic [AW-1:0]    r_rd;
    logic             r_hh;

    logic             r_busy;
    logic             r_done;
    logic             r_regwr;
    logic [AW-1:0]    r_rw;
    logic [WIDTH-1:0] r_busw;

    logic             w_last;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    assign w_last = (r_cnt == LAST_CNT);

    // One add/shift step of the multiplier.
    // The add cannot overflow WIDTH+1 bits because r_hi < 2^WIDTH after every shift.
    always_comb begin
        w_sum     = r_hi;
        w_hi_next = '0;
        w_lo_next = '0;
        if (r_lo[0]) begin
            w_sum = r_hi + {1'b0, r_a};
        end else begin
            w_sum = r_hi;
        end
        w_hi_next = w_sum >> 1;
        w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end

    // Next-state logic for the IDLE -> RUN -> WB -> IDLE sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_WB;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_rd   <= '0;
            r_hh   <= 1'b0;
            r_rw   <= '0;
            r_busw <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a   <= BusA;
                        r_lo  <= BusB;
                        r_hi  <= '0;
                        r_cnt <= '0;
                        r_rd  <= Rd;
                        r_hh  <= HighHalf;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_next;
                    r_lo  <= w_lo_next;
                    r_cnt <= r_cnt + CNTW'(1);
                    // Capture the result from this edge's update so it is visible with Done.
                    if (w_last) begin
                        r_rw   <= r_rd;
                        r_busw <= r_hh ? w_hi_next[WIDTH-1:0] : w_lo_next;
                    end
                end
                S_WB: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_regwr <= 1'b0;
        end else begin
            r_busy  <= (w_next_state != S_IDLE);
            r_done  <= (w_next_state == S_WB);
            r_regwr <= (w_next_state == S_WB) && (r_rd != ZERO_REG);
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign RegWr = r_regwr;
    assign RW    = r_rw;
    assign BusW  = r_busw;

endmodule
